pc_ras: RTL and testbench

//  Parametrised program counter with a return-address stack (RAS) for CALL/RET.
//  It adds absolute jump, short/long flag-conditional relative branches, and subroutine call/return.
//  It sits in the fetch stage. Its address output drives instruction memory directly.
//  The decoder supplies op, targets and offsets. The ALU supplies flag.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_ras_stack.sv | 59 +++++
 rtl/pc_ras.sv | 114 +++++++++++
 tb/tb_pc_ras.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
//   branch_t : encoding of the decoder's op field
//   OP_W     : width of the op field
//   sext     : sign-extend the low w bits of v to 32 bits; the caller then
//              truncates the result to the address width
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SEQ  = 3'd0,
    JMP  = 3'd1,
    BRS  = 3'd2,
    BRL  = 3'd3,
    CALL = 3'd4,
    RET  = 3'd5
  } branch_t;

  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << w;
    return v[w-1] ? (v | m) : (v & ~m);
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Return-address LIFO, DEPTH entries of AW bits.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  store wdata on top (dropped when full)
//   pop          discard top entry (ignored when empty)
//   rdata        current top entry (combinational read)
//   empty, full  registered, reflect the pointer after the update
// Callers are expected not to raise push and pop together; push wins if they do.
module pc_ras_stack
  #(parameter int AW    = 7,
    parameter int DEPTH = 4)
  (input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] wdata,
   output logic [AW-1:0] rdata,
   output logic          empty,
   output logic          full);

  // Pointer counts entries (0..DEPTH); storage index needs one bit less.
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] wr_idx, top_idx;
  logic [AW-1:0] mem [0:(1<<IW)-1];
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign wr_idx  = IW'(ptr);
  assign top_idx = IW'(ptr - PW'(1));
  assign rdata   = mem[top_idx];

  always_comb begin
    ptr_nxt = ptr;
    if (do_push)     ptr_nxt = ptr + PW'(1);
    else if (do_pop) ptr_nxt = ptr - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      empty <= (ptr_nxt == '0);
      full  <= (ptr_nxt == PW'(DEPTH));
    end
  end

  // Entry contents need no reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with return-address stack.
// Ports:
//   clk, reset        clock, synchronous active-high reset (loads start_addr)
//   halt              freeze PC and RAS, op ignored
//   start_addr        PC value after reset
//   op, flag          branch op (pc_pkg::branch_t); relative branches taken on flag==0
//   abs_addr          JMP/CALL target
//   short_off/long_off signed offsets for BRS/BRL
//   address           registered PC, drives instruction memory
//   ras_empty/full    RAS occupancy
//   ras_err           sticky overflow/underflow, cleared only by reset
//   taken_cnt         saturating taken-branch counter (only when PC_PERF_EN is defined)
// Optional feature macro: PC_PERF_EN
module pc_ras
  import pc_pkg::*;
  #(parameter int AW        = 7,
    parameter int SOFF_W    = 3,
    parameter int LOFF_W    = 6,
    parameter int RAS_DEPTH = 4)
  (input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic [AW-1:0]     start_addr,
   input  logic [OP_W-1:0]   op,
   input  logic              flag,
   input  logic [AW-1:0]     abs_addr,
   input  logic [SOFF_W-1:0] short_off,
   input  logic [LOFF_W-1:0] long_off,
   output logic [AW-1:0]     address,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
`ifdef PC_PERF_EN
   ,output logic [15:0]      taken_cnt
`endif
  );

  logic [AW-1:0] addr_inc, addr_soff, addr_loff, addr_nxt, ras_top;
  logic          push, pop, err_evt;

  // All arithmetic at AW bits so wrap is silent.
  assign addr_inc  = address + AW'(1);
  assign addr_soff = address + AW'(sext(32'(short_off), SOFF_W));
  assign addr_loff = address + AW'(sext(32'(long_off), LOFF_W));

  always_comb begin
    addr_nxt = addr_inc;
    push     = 1'b0;
    pop      = 1'b0;
    err_evt  = 1'b0;
    case (branch_t'(op))
      JMP:  addr_nxt = abs_addr;
      BRS:  addr_nxt = flag ? addr_inc : addr_soff;
      BRL:  addr_nxt = flag ? addr_inc : addr_loff;
      CALL: begin
        // Jump is taken even when the push will be dropped.
        addr_nxt = abs_addr;
        push     = ~halt;
        err_evt  = ras_full;
      end
      RET: begin
        if (ras_empty) begin
          err_evt = 1'b1;
        end else begin
          addr_nxt = ras_top;
          pop      = ~halt;
        end
      end
      default: addr_nxt = addr_inc;
    endcase
  end

  pc_ras_stack #(.AW(AW), .DEPTH(RAS_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (addr_inc),
    .rdata (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      address <= start_addr;
      ras_err <= 1'b0;
    end else if (!halt) begin
      address <= addr_nxt;
      if (err_evt) ras_err <= 1'b1;
    end
  end

`ifdef PC_PERF_EN
  logic taken;

  always_comb begin
    case (branch_t'(op))
      JMP, CALL: taken = 1'b1;
      BRS, BRL:  taken = ~flag;
      RET:       taken = ~ras_empty;
      default:   taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      taken_cnt <= '0;
    else if (!halt && taken && taken_cnt != 16'hFFFF)
      taken_cnt <= taken_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (AW=7, SOFF_W=3, LOFF_W=6, RAS_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pc_ras;
  import pc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, halt, flag;
  logic [6:0] start_addr, abs_addr, address;
  logic [2:0] op, short_off;
  logic [5:0] long_off;
  logic       ras_empty, ras_full, ras_err;
`ifdef PC_PERF_EN
  logic [15:0] taken_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_ras #(.AW(7), .SOFF_W(3), .LOFF_W(6), .RAS_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .start_addr (start_addr),
    .op         (op),
    .flag       (flag),
    .abs_addr   (abs_addr),
    .short_off  (short_off),
    .long_off   (long_off),
    .address    (address),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
`ifdef PC_PERF_EN
    ,.taken_cnt (taken_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-halted cycle with the given op.
  task automatic do_op(input logic [2:0] o, input logic [6:0] a, input logic f,
                       input logic [2:0] so, input logic [5:0] lo);
    op = o; abs_addr = a; flag = f; short_off = so; long_off = lo;
    tick();
    op = SEQ;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; flag = 1'b0; start_addr = 7'h10;
    op = SEQ; abs_addr = '0; short_off = '0; long_off = '0;

    // 1. reset, sequential, halt
    tick();
    chk("rst_addr",  32'(address),   32'h10);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full",  32'(ras_full),  32'd0);
    chk("rst_err",   32'(ras_err),   32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) do_op(SEQ, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("seq3", 32'(address), 32'h13);
    halt = 1'b1;
    do_op(JMP, 7'h55, 1'b0, 3'd0, 6'd0);
    do_op(SEQ, 7'h0,  1'b0, 3'd0, 6'd0);
    chk("halt_hold", 32'(address), 32'h13);
    halt = 1'b0;

    // 2. relative branches and wrap
    do_op(BRS, 7'h0, 1'b0, 3'b110, 6'd0);
    chk("brs_taken_neg", 32'(address), 32'h11);
    do_op(BRS, 7'h0, 1'b1, 3'b110, 6'd0);
    chk("brs_untaken", 32'(address), 32'h12);
    do_op(JMP, 7'h7F, 1'b0, 3'd0, 6'd0);
    chk("jmp", 32'(address), 32'h7F);
    do_op(BRL, 7'h0, 1'b0, 3'd0, 6'd31);
    chk("brl_wrap", 32'(address), 32'h1E);
    do_op(BRL, 7'h0, 1'b1, 3'd0, 6'd31);
    chk("brl_untaken", 32'(address), 32'h1F);
    do_op(JMP, 7'h7F, 1'b0, 3'd0, 6'd0);
    do_op(SEQ, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("seq_wrap", 32'(address), 32'h00);
    do_op(BRL, 7'h0, 1'b0, 3'd0, 6'b100000);
    chk("brl_neg_wrap", 32'(address), 32'h60);
    do_op(3'b111, 7'h33, 1'b0, 3'd0, 6'd0);
    chk("reserved_op", 32'(address), 32'h61);

    // 3. single call/return
    do_op(JMP, 7'h05, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h40, 1'b0, 3'd0, 6'd0);
    chk("call_addr",  32'(address),   32'h40);
    chk("call_empty", 32'(ras_empty), 32'd0);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("ret_addr",  32'(address),   32'h06);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // 4. fill, overflow, drain, underflow
    do_op(JMP, 7'h10, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h20, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h30, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h40, 1'b0, 3'd0, 6'd0);
    chk("full_not_yet", 32'(ras_full), 32'd0);
    do_op(CALL, 7'h50, 1'b0, 3'd0, 6'd0);
    chk("full", 32'(ras_full), 32'd1);
    chk("err_before_ovf", 32'(ras_err), 32'd0);
    do_op(CALL, 7'h60, 1'b0, 3'd0, 6'd0);
    chk("ovf_addr", 32'(address), 32'h60);
    chk("ovf_err",  32'(ras_err), 32'd1);
    chk("ovf_full", 32'(ras_full), 32'd1);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("ret1", 32'(address), 32'h41);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("ret2", 32'(address), 32'h31);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("ret3", 32'(address), 32'h21);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("ret4", 32'(address), 32'h11);
    chk("drained_empty", 32'(ras_empty), 32'd1);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("unf_addr", 32'(address), 32'h12);
    chk("unf_err",  32'(ras_err), 32'd1);

    // 5. halt with CALL, reset mid-nesting
    do_op(CALL, 7'h33, 1'b0, 3'd0, 6'd0);
    halt = 1'b1;
    do_op(CALL, 7'h70, 1'b0, 3'd0, 6'd0);
    halt = 1'b0;
    chk("halt_call_addr", 32'(address), 32'h33);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("halt_no_push", 32'(address), 32'h13);
    chk("halt_no_push_empty", 32'(ras_empty), 32'd1);
    do_op(CALL, 7'h44, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h55, 1'b0, 3'd0, 6'd0);
    reset = 1'b1; start_addr = 7'h08;
    do_op(CALL, 7'h66, 1'b0, 3'd0, 6'd0);
    reset = 1'b0;
    chk("rst2_addr",  32'(address),   32'h08);
    chk("rst2_empty", 32'(ras_empty), 32'd1);
    chk("rst2_err",   32'(ras_err),   32'd0);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("rst2_unf_addr", 32'(address), 32'h09);

`ifdef PC_PERF_EN
    // 6. taken counter
    reset = 1'b1; tick(); reset = 1'b0;
    chk("perf_rst", 32'(taken_cnt), 32'd0);
    do_op(JMP, 7'h10, 1'b0, 3'd0, 6'd0);
    do_op(BRS, 7'h0, 1'b0, 3'd1, 6'd0);
    do_op(BRS, 7'h0, 1'b1, 3'd1, 6'd0);
    do_op(SEQ, 7'h0, 1'b0, 3'd0, 6'd0);
    do_op(CALL, 7'h20, 1'b0, 3'd0, 6'd0);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    chk("perf_cnt4", 32'(taken_cnt), 32'd4);
    do_op(RET, 7'h0, 1'b0, 3'd0, 6'd0);
    halt = 1'b1;
    do_op(JMP, 7'h10, 1'b0, 3'd0, 6'd0);
    halt = 1'b0;
    chk("perf_no_count", 32'(taken_cnt), 32'd4);
    op = JMP; abs_addr = 7'h10;
    for (int i = 0; i < 65531; i++) tick();
    chk("perf_max", 32'(taken_cnt), 32'hFFFF);
    tick(); tick();
    chk("perf_sat", 32'(taken_cnt), 32'hFFFF);
    op = SEQ;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
